escape_maneuver_fsm: RTL
========================

# escape_maneuver_fsm

Parametrised obstacle-escape controller for the motion path: on `enable` it reverses for a programmable time, pauses, spins by a latched random angle, then drives straight. Bumps while spinning or driving restart the sequence with the spin direction alternated, up to a retry limit, after which it parks in a fault state. It sits under the motion decision FSM, which owns `enable`, and feeds speed/command to the drive layer.

## Interface
- `SPEED_W`, 3: width of `output_speed`.
- `ANGLE_W`, 10: width of `random_angle` / `motion_command`.
- `TIMER_W`, 16: width of the shared phase timer.
- `REV_CYCLES`, 256: cycles spent reversing (≥1, < 2^TIMER_W).
- `PAUSE_CYCLES`, 16: zero-speed settle cycles between reverse and spin (≥1).
- `SPIN_TIMEOUT`, 4096: maximum ROTATE cycles before the spin counts as failed.
- `MAX_RETRIES`, 3: number of restarts allowed before FAULT (≥1).
- `REV_SPEED`, 3'b101; `FWD_SPEED`, 3'b011; `SPIN_SPEED`, 3'b011: speed codes.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: maneuver request; low aborts to IDLE.
- `bump` in 1: obstacle contact, level.
- `done_spin` in 1: drive layer reports the commanded angle is reached.
- `random_angle` in ANGLE_W: angle source, sampled once per spin.
- `output_speed` out SPEED_W: registered speed code.
- `motion_command` out ANGLE_W: registered angle command; 0 means straight.
- `busy` out 1: high in REVERSE, PAUSE, or ROTATE.
- `fault` out 1: high in FAULT.
- `retry_count` out clog2(MAX_RETRIES+1): restarts taken in the current maneuver.

## Operation
- States: IDLE, REVERSE, PAUSE, ROTATE, STRAIGHT, FAULT.
- IDLE: `enable`=1 goes to REVERSE and clears `retry_count`.
- REVERSE: `output_speed`=REV_SPEED, command 0. After REV_CYCLES cycles, go to PAUSE. `bump` is ignored.
- PAUSE: speed 0, command 0. After PAUSE_CYCLES cycles, go to ROTATE, latching `random_angle` into an internal angle register on the transition.
- ROTATE: speed SPIN_SPEED. Command is the latched angle when `retry_count` is even, and its two's-complement negation mod 2^ANGLE_W when odd (so 0 stays 0).
  - `done_spin` goes to STRAIGHT.
  - Otherwise, `bump` or the timer reaching SPIN_TIMEOUT counts as a failed attempt.
- STRAIGHT: speed FWD_SPEED, command 0. Stays here until `bump` (failed attempt) or `enable` low.
- Failed attempt: if `retry_count` < MAX_RETRIES, increment it and go to REVERSE; otherwise go to FAULT.
- FAULT: speed 0, command 0, `fault`=1. Held until `enable` low.
- Priority within a cycle: `enable` low > `done_spin` > `bump` > timer expiry.
- `enable` low in any state: IDLE next cycle, speed 0, command 0. The counter and latched angle keep their values until the next IDLE exit.

## Timing
- Reset (async, `rst`=0): state IDLE, `output_speed`=0, `motion_command`=0, `busy`=0, `fault`=0, `retry_count`=0, timer 0, angle register 0.
- Outputs are registered from next-state decode, so outputs always match the state register in the same cycle. Latency is one cycle from input to output.
- Timer clears on every state change and increments each cycle within REVERSE, PAUSE, and ROTATE.
- REVERSE exits when the timer equals REV_CYCLES-1, giving exactly REV_CYCLES cycles of REV_SPEED. PAUSE exits the same way.
- ROTATE times out when the timer equals SPIN_TIMEOUT-1.
- Timer width checks: TIMER_W must hold every *_CYCLES value. The timer never wraps; it stays within each terminal count.
- Reset asserted mid-maneuver forces outputs to 0 immediately (asynchronously).

## Structure
- Shared motion package holds:
  - the state enum;
  - the speed-code constants REV/FWD/ZERO;
  - the straight-command constant 0.
- One natural sub-module is `phase_timer`: a TIMER_W counter with a synchronous clear and a terminal-count compare.
- The FSM, angle latch/mirror, and retry counter stay in the top module.

## Test plan
- Reset then `enable`=1 with REV_CYCLES=8, PAUSE_CYCLES=2: expect exactly 8 cycles of speed 3'b101, then 2 cycles of speed 0, then ROTATE with command = sampled angle, `busy`=1.
- `random_angle`=10'd100 latched, then the input changes to 10'd7 during ROTATE: `motion_command` stays 100. `done_spin` gives STRAIGHT, speed 3'b011, command 0, `busy`=0.
- `bump` in STRAIGHT: `retry_count`=1, REVERSE, and the next ROTATE command is 10'd924 (mirror of 100). A `bump` during REVERSE has no effect.
- No `done_spin` with SPIN_TIMEOUT=16: ROTATE lasts 16 cycles, then REVERSE with `retry_count` incremented. With MAX_RETRIES=3, the fourth failure gives FAULT, `fault`=1, speed 0.
- `done_spin` and `bump` in the same ROTATE cycle: STRAIGHT, `retry_count` unchanged.
- `enable` dropped mid-REVERSE: IDLE next cycle with outputs 0. `rst`=0 mid-ROTATE: outputs 0 without a clock edge. Re-enable clears `retry_count`.

Source files
------------

// File: rtl/escape_maneuver_fsm_pkg.sv
// Shared motion definitions: escape-maneuver state codes, speed codes and
// the straight-ahead command value used by the motion path.
package escape_maneuver_fsm_pkg;

  // Maneuver phases. The encoding is fixed so that logic-vector state
  // registers in older blocks can compare against the same values.
  typedef enum logic [2:0] {
    MS_IDLE     = 3'd0,
    MS_REVERSE  = 3'd1,
    MS_PAUSE    = 3'd2,
    MS_ROTATE   = 3'd3,
    MS_STRAIGHT = 3'd4,
    MS_FAULT    = 3'd5
  } motion_state_e;

  localparam logic [2:0] ST_IDLE     = MS_IDLE;
  localparam logic [2:0] ST_REVERSE  = MS_REVERSE;
  localparam logic [2:0] ST_PAUSE    = MS_PAUSE;
  localparam logic [2:0] ST_ROTATE   = MS_ROTATE;
  localparam logic [2:0] ST_STRAIGHT = MS_STRAIGHT;
  localparam logic [2:0] ST_FAULT    = MS_FAULT;

  // Speed codes understood by the drive layer.
  localparam logic [2:0] SPD_ZERO = 3'b000;
  localparam logic [2:0] SPD_REV  = 3'b101;
  localparam logic [2:0] SPD_FWD  = 3'b011;
  localparam logic [2:0] SPD_SPIN = 3'b011;

  // Angle command meaning "drive straight".
  localparam int CMD_STRAIGHT = 0;

endpackage

// File: rtl/escape_maneuver_fsm_if.sv
// Bundle between the motion decision FSM (master) and the escape
// maneuver controller (slave).
interface escape_maneuver_fsm_if #(
  parameter int SPEED_W = 3,
  parameter int ANGLE_W = 10,
  parameter int RETRY_W = 2
);
  logic               enable;
  logic               bump;
  logic               done_spin;
  logic [ANGLE_W-1:0] random_angle;
  logic [SPEED_W-1:0] output_speed;
  logic [ANGLE_W-1:0] motion_command;
  logic               busy;
  logic               fault;
  logic [RETRY_W-1:0] retry_count;

  modport master (
    output enable, bump, done_spin, random_angle,
    input  output_speed, motion_command, busy, fault, retry_count
  );

  modport slave (
    input  enable, bump, done_spin, random_angle,
    output output_speed, motion_command, busy, fault, retry_count
  );
endinterface

// File: rtl/escape_maneuver_fsm_phase_timer.sv
// Shared phase timer: counts cycles inside a phase, clears on a phase
// change and flags when the count reaches the current terminal value.
module escape_maneuver_fsm_phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  input  logic [TIMER_W-1:0] terminal,
  output logic               at_terminal
);
  logic [TIMER_W-1:0] count_reg;

  // Count up while enabled; hold at the terminal so the timer never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != terminal)) begin
      count_reg <= count_reg + TIMER_W'(1);
    end
  end

  assign at_terminal = (count_reg == terminal);
endmodule

// File: rtl/escape_maneuver_fsm.sv
// Obstacle-escape controller: reverse, pause, spin by a latched random
// angle, then drive straight; bumps restart the sequence with the spin
// direction alternated until the retry budget runs out.
module escape_maneuver_fsm
  import escape_maneuver_fsm_pkg::*;
#(
  parameter int               SPEED_W      = 3,
  parameter int               ANGLE_W      = 10,
  parameter int               TIMER_W      = 16,
  parameter int               REV_CYCLES   = 256,
  parameter int               PAUSE_CYCLES = 16,
  parameter int               SPIN_TIMEOUT = 4096,
  parameter int               MAX_RETRIES  = 3,
  parameter logic [SPEED_W-1:0] REV_SPEED  = SPD_REV,
  parameter logic [SPEED_W-1:0] FWD_SPEED  = SPD_FWD,
  parameter logic [SPEED_W-1:0] SPIN_SPEED = SPD_SPIN
) (
  input logic                 clk,
  input logic                 rst,
  escape_maneuver_fsm_if.slave bus
);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  logic [2:0]         state_reg, state_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic [ANGLE_W-1:0] angle_reg, angle_next;
  logic [SPEED_W-1:0] speed_reg, speed_next;
  logic [ANGLE_W-1:0] command_reg, command_next;
  logic               busy_reg, busy_next;
  logic               fault_reg, fault_next;

  logic               timer_clear;
  logic               timer_inc;
  logic               timer_done;
  logic [TIMER_W-1:0] timer_terminal;

  // Select the terminal count that ends the current timed phase.
  always_comb begin
    timer_terminal = '0;
    case (state_reg)
      ST_REVERSE: timer_terminal = TIMER_W'(REV_CYCLES - 1);
      ST_PAUSE:   timer_terminal = TIMER_W'(PAUSE_CYCLES - 1);
      ST_ROTATE:  timer_terminal = TIMER_W'(SPIN_TIMEOUT - 1);
      default:    timer_terminal = '0;
    endcase
  end

  // The timer restarts on every phase change and only runs in timed phases.
  assign timer_clear = (state_next != state_reg);
  assign timer_inc   = (state_reg == ST_REVERSE) || (state_reg == ST_PAUSE) ||
                       (state_reg == ST_ROTATE);

  escape_maneuver_fsm_phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_phase_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (timer_clear),
    .inc         (timer_inc),
    .terminal    (timer_terminal),
    .at_terminal (timer_done)
  );

  // Next-state, retry and angle-latch decode; enable low overrides all.
  always_comb begin
    logic failed;
    failed     = 1'b0;
    state_next = state_reg;
    retry_next = retry_reg;
    angle_next = angle_reg;

    if (!bus.enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_REVERSE;
          retry_next = '0;
        end
        ST_REVERSE: begin
          if (timer_done) state_next = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (timer_done) begin
            state_next = ST_ROTATE;
            angle_next = bus.random_angle;
          end
        end
        ST_ROTATE: begin
          if (bus.done_spin) state_next = ST_STRAIGHT;
          else if (bus.bump || timer_done) failed = 1'b1;
        end
        ST_STRAIGHT: begin
          if (bus.bump) failed = 1'b1;
        end
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_IDLE;
      endcase

      if (failed) begin
        if (retry_reg < RETRY_W'(MAX_RETRIES)) begin
          retry_next = retry_reg + RETRY_W'(1);
          state_next = ST_REVERSE;
        end else begin
          state_next = ST_FAULT;
        end
      end
    end
  end

  // Output decode from the next state so outputs line up with the state register.
  always_comb begin
    speed_next   = '0;
    command_next = ANGLE_W'(CMD_STRAIGHT);
    busy_next    = 1'b0;
    fault_next   = 1'b0;
    case (state_next)
      ST_REVERSE: begin
        speed_next = REV_SPEED;
        busy_next  = 1'b1;
      end
      ST_PAUSE: busy_next = 1'b1;
      ST_ROTATE: begin
        speed_next   = SPIN_SPEED;
        busy_next    = 1'b1;
        // Odd attempts spin the other way: two's-complement mirror of the angle.
        command_next = retry_next[0] ? ({ANGLE_W{1'b0}} - angle_next) : angle_next;
      end
      ST_STRAIGHT: speed_next = FWD_SPEED;
      ST_FAULT:    fault_next = 1'b1;
      default:     speed_next = '0;
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      retry_reg   <= '0;
      angle_reg   <= '0;
      speed_reg   <= '0;
      command_reg <= '0;
      busy_reg    <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      retry_reg   <= retry_next;
      angle_reg   <= angle_next;
      speed_reg   <= speed_next;
      command_reg <= command_next;
      busy_reg    <= busy_next;
      fault_reg   <= fault_next;
    end
  end

  assign bus.output_speed   = speed_reg;
  assign bus.motion_command = command_reg;
  assign bus.busy           = busy_reg;
  assign bus.fault          = fault_reg;
  assign bus.retry_count    = retry_reg;
endmodule
